// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, and
// single-cycle press / release / long-press pulses plus a debounced level.
module key_debounce #(
  parameter int unsigned CNT_MAX  = 999_999,
  parameter int unsigned LONG_MAX = 49_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_long,
  output logic key_level
);

  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned HW = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_key_sync;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_nxt;
  logic [HW-1:0] w_hold_inc;
  logic          w_flag_nxt;
  logic          w_rel_nxt;
  logic          w_long_nxt;
  logic          w_level_nxt;

  // Synchronizer idles at 1 so a reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key_sync = r_sync2;
  assign w_hold_inc = r_hold + HW'(1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      key_flag    <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_level   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      key_flag    <= w_flag_nxt;
      key_release <= w_rel_nxt;
      key_long    <= w_long_nxt;
      key_level   <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_flag_nxt  = 1'b0;
    w_rel_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_key_sync) begin
          w_state_nxt = FILT_DN;
          w_cnt_nxt   = '0;
        end
      end
      FILT_DN: begin
        if (w_key_sync) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
          w_flag_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DOWN: begin
        if (w_key_sync) begin
          w_state_nxt = FILT_UP;
          w_cnt_nxt   = '0;
        end
      end
      FILT_UP: begin
        if (!w_key_sync) begin
          w_state_nxt = DOWN;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_rel_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Hold counter saturates; a release confirmed on the same edge wins over long-press.
    if ((r_state == DOWN || r_state == FILT_UP) && r_hold != HOLD_MAX) begin
      w_hold_nxt = w_hold_inc;
      w_long_nxt = (w_hold_inc == HOLD_MAX) && !w_rel_nxt;
    end
    w_level_nxt = (w_state_nxt == DOWN) || (w_state_nxt == FILT_UP);
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed and randomized stimulus for key_debounce, checked every cycle
// against a run-length reference model of the debounced key.
module tb_key_debounce;

  localparam int unsigned CNT_MAX  = 20;
  localparam int unsigned LONG_MAX = 100;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_in;
  logic key_flag;
  logic key_release;
  logic key_long;
  logic key_level;

  always #5 sys_clk = ~sys_clk;

  key_debounce #(
    .CNT_MAX (CNT_MAX),
    .LONG_MAX(LONG_MAX)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_flag   (key_flag),
    .key_release(key_release),
    .key_long   (key_long),
    .key_level  (key_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: key_sync is key_in delayed by two sampling edges; the
  // debounced level flips once CNT_MAX+1 consecutive samples disagree with it.
  bit          pipe[$];
  bit          m_level;
  int unsigned m_run;
  int unsigned m_since;
  bit          m_long_done;
  bit          e_flag, e_rel, e_long;

  int ecount = 0;
  int last_flag_edge, last_rel_edge, last_long_edge;
  int n_flag = 0, n_rel = 0, n_long = 0;
  int coins = 0, n_cola = 0;
  bit prev_flag = 0;

  function automatic void model_reset();
    pipe = {1'b1, 1'b1};
    m_level = 1'b0;
    m_run = 0;
    m_since = 0;
    m_long_done = 1'b1;
    e_flag = 1'b0;
    e_rel = 1'b0;
    e_long = 1'b0;
  endfunction

  function automatic void model_step(input bit kin);
    bit ks;
    bit was_pressed;
    ks = pipe.pop_front();
    pipe.push_back(kin);
    e_flag = 1'b0;
    e_rel = 1'b0;
    e_long = 1'b0;
    was_pressed = m_level;
    if ((ks == 1'b0) != m_level) m_run++;
    else m_run = 0;
    if (m_run == CNT_MAX + 1) begin
      m_level = !m_level;
      m_run = 0;
      if (m_level) begin
        e_flag = 1'b1;
        m_since = 0;
        m_long_done = 1'b0;
      end else begin
        e_rel = 1'b1;
      end
    end
    if (was_pressed && !e_rel) begin
      m_since++;
      if (m_since == LONG_MAX && !m_long_done) begin
        e_long = 1'b1;
        m_long_done = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b (edge %0d)", tag, obs, exp, ecount);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit kin;
    kin = key_in;
    @(posedge sys_clk);
    ecount++;
    if (sys_rst_n) model_step(kin);
    #1;
    if (!sys_rst_n) begin
      chk("rst_flag", key_flag, 1'b0);
      chk("rst_release", key_release, 1'b0);
      chk("rst_long", key_long, 1'b0);
      chk("rst_level", key_level, 1'b0);
    end else begin
      chk("flag", key_flag, e_flag);
      chk("release", key_release, e_rel);
      chk("long", key_long, e_long);
      chk("level", key_level, m_level);
    end
    chk("pulse_excl", (int'(key_flag) + int'(key_release) + int'(key_long)) > 1, 1'b0);
    chk("flag_back_to_back", key_flag && prev_flag, 1'b0);
    prev_flag = key_flag;
    if (key_flag) begin
      n_flag++;
      last_flag_edge = ecount;
      coins++;
      if (coins == 3) begin
        n_cola++;
        coins = 0;
      end
    end
    if (key_release) begin
      n_rel++;
      last_rel_edge = ecount;
    end
    if (key_long) begin
      n_long++;
      last_long_edge = ecount;
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    key_in = v;
    repeat (n) tick();
  endtask

  task automatic bounce(input int unsigned total);
    int unsigned rem;
    int unsigned len;
    logic v;
    rem = total;
    v = 1'b0;
    while (rem > 0) begin
      len = $urandom_range(1, 3);
      if (len > rem) len = rem;
      hold(v, len);
      rem -= len;
      v = ~v;
    end
  endtask

  initial begin
    int start, f0, r0, l0, c0;
    sys_rst_n = 1'b0;
    key_in = 1'b1;
    model_reset();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    hold(1'b1, 10);

    // Clean press and release
    f0 = n_flag; r0 = n_rel;
    start = ecount + 1;
    hold(1'b0, 60);
    chk_int("press_count", n_flag - f0, 1);
    chk_int("press_latency", last_flag_edge - start + 1, 23);
    chk("press_level", key_level, 1'b1);
    start = ecount + 1;
    hold(1'b1, 60);
    chk_int("release_count", n_rel - r0, 1);
    chk_int("release_latency", last_rel_edge - start + 1, 23);
    chk("release_level", key_level, 1'b0);

    // Press bounce: low runs of 5, 12, 19 never reach the window
    f0 = n_flag; r0 = n_rel; l0 = n_long;
    hold(1'b0, 5);  hold(1'b1, 3);
    hold(1'b0, 12); hold(1'b1, 3);
    hold(1'b0, 19); hold(1'b1, 40);
    chk_int("bounce_flags", n_flag - f0, 0);
    chk_int("bounce_releases", n_rel - r0, 0);
    chk_int("bounce_longs", n_long - l0, 0);

    // Release bounce
    hold(1'b0, 40);
    f0 = n_flag; r0 = n_rel;
    hold(1'b1, 10); hold(1'b0, 4);
    start = ecount + 1;
    hold(1'b1, 40);
    chk_int("relbounce_releases", n_rel - r0, 1);
    chk_int("relbounce_latency", last_rel_edge - start + 1, 23);
    chk_int("relbounce_no_reflag", n_flag - f0, 0);

    // Long press
    f0 = n_flag; r0 = n_rel; l0 = n_long;
    start = ecount + 1;
    hold(1'b0, 200);
    chk_int("long_flag_latency", last_flag_edge - start + 1, 23);
    chk_int("long_count", n_long - l0, 1);
    chk_int("long_delay", last_long_edge - last_flag_edge, int'(LONG_MAX));
    hold(1'b1, 40);
    chk_int("long_release", n_rel - r0, 1);
    chk_int("long_no_repeat", n_long - l0, 1);

    // Reset in the middle of the press filter, key still held
    key_in = 1'b0;
    repeat (13) tick();
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_level", key_level, 1'b0);
    chk("midrst_flag", key_flag, 1'b0);
    model_reset();
    repeat (3) tick();
    sys_rst_n = 1'b1;
    f0 = n_flag;
    start = ecount + 1;
    hold(1'b0, 40);
    chk_int("midrst_fresh_flag", n_flag - f0, 1);
    chk_int("midrst_latency", last_flag_edge - start + 1, 23);
    hold(1'b1, 40);

    // Randomized segments against the model
    for (int s = 0; s < 40; s++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 45));
    end
    hold(1'b1, 60);
    chk("random_settled_level", key_level, 1'b0);

    // Vending consumer: three bouncy presses buy one cola
    coins = 0;
    f0 = n_flag; c0 = n_cola;
    for (int p = 0; p < 3; p++) begin
      bounce(30);
      hold(1'b0, 40);
      bounce(30);
      hold(1'b1, 40);
    end
    chk_int("vend_flags", n_flag - f0, 3);
    chk_int("vend_cola", n_cola - c0, 1);
    chk_int("vend_coins_left", coins, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
